// File: rtl/peripheral_dbg_jsp_apb_mch.sv
// Multi-channel JTAG serial port, APB side: per-channel RX/TX byte FIFOs with
// occupancy, status and interrupt-enable registers plus APB error responses.
module peripheral_dbg_jsp_apb_mch #(
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    jsp_PSEL,
    input  logic                    jsp_PENABLE,
    input  logic                    jsp_PWRITE,
    input  logic [ADDR_WIDTH-1:0]   jsp_PADDR,
    input  logic [7:0]              jsp_PWDATA,
    output logic [7:0]              jsp_PRDATA,
    output logic                    jsp_PREADY,
    output logic                    jsp_PSLVERR,
    output logic                    int_o,
    input  logic [CHANNELS*8-1:0]   host_rx_data_i,
    input  logic [CHANNELS-1:0]     host_rx_valid_i,
    output logic [CHANNELS-1:0]     host_rx_ready_o,
    output logic [CHANNELS*8-1:0]   host_tx_data_o,
    output logic [CHANNELS-1:0]     host_tx_valid_o,
    input  logic [CHANNELS-1:0]     host_tx_ready_i
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CIW = ADDR_WIDTH - 3;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic                  access;
    logic [2:0]            reg_sel;
    logic [CIW-1:0]        ch_idx;
    logic                  ch_ok;
    logic [CHANNELS*8-1:0] ch_rdata;
    logic [CHANNELS-1:0]   ch_err;
    logic [CHANNELS-1:0]   int_src;
    logic                  unused_pwdata;

    assign access        = jsp_PSEL & jsp_PENABLE;
    assign reg_sel       = jsp_PADDR[2:0];
    assign ch_idx        = jsp_PADDR[ADDR_WIDTH-1:3];
    assign ch_ok         = (int'(ch_idx) < CHANNELS);
    assign jsp_PREADY    = 1'b1;
    assign unused_pwdata = ^{jsp_PWDATA[7:4], jsp_PWDATA[2]};

    // Host streams: a byte moves on every PCLK edge where valid and ready are both
    // high; our ready/valid come only from registered FIFO counts, never from the
    // host's own valid/ready inputs.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [7:0]    rx_mem [DEPTH];
        logic [7:0]    tx_mem [DEPTH];
        logic [PW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
        logic [CW-1:0] rx_cnt, tx_cnt;
        logic [1:0]    ier;
        logic          err;
        logic          hit, data_rd, data_wr;
        logic          rx_empty, rx_full, tx_empty, tx_full;
        logic          rx_push, rx_pop, tx_push, tx_pop;
        logic [7:0]    rdata;

        assign hit      = access & ch_ok & (ch_idx == CIW'(c));
        assign data_rd  = hit & ~jsp_PWRITE & (reg_sel == 3'd0);
        assign data_wr  = hit &  jsp_PWRITE & (reg_sel == 3'd0);
        assign rx_empty = (rx_cnt == '0);
        assign rx_full  = (rx_cnt == FULL);
        assign tx_empty = (tx_cnt == '0);
        assign tx_full  = (tx_cnt == FULL);
        assign rx_push  = host_rx_valid_i[c] & ~rx_full;
        assign rx_pop   = data_rd & ~rx_empty;
        assign tx_push  = data_wr & ~tx_full;
        assign tx_pop   = host_tx_ready_i[c] & ~tx_empty;

        assign host_rx_ready_o[c]      = ~rx_full;
        assign host_tx_valid_o[c]      = ~tx_empty;
        assign host_tx_data_o[8*c +: 8] = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];
        assign int_src[c] = (ier[0] & ~rx_empty) | (ier[1] & tx_empty);

        always_comb begin
            rdata = 8'h00;
            case (reg_sel)
                3'd0:    rdata = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
                3'd1:    rdata = {6'b0, ier};
                3'd2:    rdata = {4'b0, err, tx_empty, ~tx_full, ~rx_empty};
                3'd3:    rdata = 8'(rx_cnt);
                3'd4:    rdata = 8'(FULL - tx_cnt);
                default: rdata = 8'h00;
            endcase
        end

        assign ch_rdata[8*c +: 8] = (hit & ~jsp_PWRITE) ? rdata : 8'h00;
        assign ch_err[c]          = (data_rd & rx_empty) | (data_wr & tx_full);

        // Storage carries no reset; stale entries are masked by the counts.
        always_ff @(posedge PCLK) begin
            if (rx_push) rx_mem[rx_wr_ptr] <= host_rx_data_i[8*c +: 8];
            if (tx_push) tx_mem[tx_wr_ptr] <= jsp_PWDATA;
        end

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                rx_cnt    <= '0;
                tx_cnt    <= '0;
                ier       <= 2'b00;
                err       <= 1'b0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
                if (rx_push & ~rx_pop)      rx_cnt <= rx_cnt + CW'(1);
                else if (~rx_push & rx_pop) rx_cnt <= rx_cnt - CW'(1);
                if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + CW'(1);
                else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - CW'(1);
                if (hit & jsp_PWRITE & (reg_sel == 3'd1)) ier <= jsp_PWDATA[1:0];
                if (ch_err[c])
                    err <= 1'b1;
                else if (hit & jsp_PWRITE & (reg_sel == 3'd2) & jsp_PWDATA[3])
                    err <= 1'b0;
            end
        end
    end

    always_comb begin
        jsp_PRDATA = 8'h00;
        for (int c = 0; c < CHANNELS; c++) jsp_PRDATA |= ch_rdata[8*c +: 8];
    end

    assign jsp_PSLVERR = (access & ~ch_ok) | (|ch_err);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) int_o <= 1'b0;
        else          int_o <= |int_src;
    end
endmodule

// File: tb/tb_peripheral_dbg_jsp_apb_mch.sv
// Bench for the multi-channel JSP: queue-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_peripheral_dbg_jsp_apb_mch;
    localparam int CH    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 6;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic            jsp_PSEL = 1'b0;
    logic            jsp_PENABLE = 1'b0;
    logic            jsp_PWRITE = 1'b0;
    logic [AW-1:0]   jsp_PADDR = '0;
    logic [7:0]      jsp_PWDATA = '0;
    logic [7:0]      jsp_PRDATA;
    logic            jsp_PREADY;
    logic            jsp_PSLVERR;
    logic            int_o;
    logic [CH*8-1:0] host_rx_data_i = '0;
    logic [CH-1:0]   host_rx_valid_i = '0;
    logic [CH-1:0]   host_rx_ready_o;
    logic [CH*8-1:0] host_tx_data_o;
    logic [CH-1:0]   host_tx_valid_o;
    logic [CH-1:0]   host_tx_ready_i = '0;

    int checks = 0;
    int errors = 0;

    peripheral_dbg_jsp_apb_mch #(.CHANNELS(CH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .jsp_PSEL(jsp_PSEL), .jsp_PENABLE(jsp_PENABLE), .jsp_PWRITE(jsp_PWRITE),
        .jsp_PADDR(jsp_PADDR), .jsp_PWDATA(jsp_PWDATA), .jsp_PRDATA(jsp_PRDATA),
        .jsp_PREADY(jsp_PREADY), .jsp_PSLVERR(jsp_PSLVERR), .int_o(int_o),
        .host_rx_data_i(host_rx_data_i), .host_rx_valid_i(host_rx_valid_i),
        .host_rx_ready_o(host_rx_ready_o), .host_tx_data_o(host_tx_data_o),
        .host_tx_valid_o(host_tx_valid_o), .host_tx_ready_i(host_tx_ready_i)
    );

    // ---------------- clock / reset ----------------
    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_rx_q [CH][$];
    logic [7:0] exp_tx_q [CH][$];
    logic [1:0] m_ier [CH] = '{default: 2'b00};
    logic       m_err [CH] = '{default: 1'b0};
    logic       m_int = 1'b0;
    int         m_rx_sz [CH];
    int         m_tx_sz [CH];
    logic       m_nxt_int;

    function automatic void exp_apb(output logic [7:0] d, output logic e);
        int ch;
        int rg;
        d = 8'h00;
        e = 1'b0;
        if (!(jsp_PSEL && jsp_PENABLE)) return;
        ch = int'(jsp_PADDR[5:3]);
        rg = int'(jsp_PADDR[2:0]);
        if (ch >= CH) begin
            e = 1'b1;
            return;
        end
        case (rg)
            0: begin
                if (jsp_PWRITE) e = (exp_tx_q[ch].size() == DEPTH);
                else if (exp_rx_q[ch].size() == 0) e = 1'b1;
                else d = exp_rx_q[ch][0];
            end
            1: d = {6'b0, m_ier[ch]};
            2: d = 8'(int'(m_err[ch]) * 8 + (exp_tx_q[ch].size() == 0 ? 4 : 0) +
                      (exp_tx_q[ch].size() < DEPTH ? 2 : 0) + (exp_rx_q[ch].size() > 0 ? 1 : 0));
            3: d = 8'(exp_rx_q[ch].size());
            4: d = 8'(DEPTH - exp_tx_q[ch].size());
            default: d = 8'h00;
        endcase
    endfunction

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int c = 0; c < CH; c++) begin
                exp_rx_q[c].delete();
                exp_tx_q[c].delete();
                m_ier[c] = 2'b00;
                m_err[c] = 1'b0;
            end
            m_int = 1'b0;
        end else begin
            m_nxt_int = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_rx_sz[c] = exp_rx_q[c].size();
                m_tx_sz[c] = exp_tx_q[c].size();
                if ((m_ier[c][0] && m_rx_sz[c] > 0) || (m_ier[c][1] && m_tx_sz[c] == 0))
                    m_nxt_int = 1'b1;
            end
            for (int c = 0; c < CH; c++) begin
                logic here;
                here = jsp_PSEL && jsp_PENABLE && (int'(jsp_PADDR[5:3]) == c);
                if (here && jsp_PADDR[2:0] == 3'd0 && !jsp_PWRITE && m_rx_sz[c] > 0)
                    void'(exp_rx_q[c].pop_front());
                if (host_rx_valid_i[c] && m_rx_sz[c] < DEPTH)
                    exp_rx_q[c].push_back(host_rx_data_i[8*c +: 8]);
                if (host_tx_ready_i[c] && m_tx_sz[c] > 0)
                    void'(exp_tx_q[c].pop_front());
                if (here && jsp_PADDR[2:0] == 3'd0 && jsp_PWRITE && m_tx_sz[c] < DEPTH)
                    exp_tx_q[c].push_back(jsp_PWDATA);
                if (here && jsp_PADDR[2:0] == 3'd1 && jsp_PWRITE)
                    m_ier[c] = jsp_PWDATA[1:0];
                if (here && jsp_PADDR[2:0] == 3'd0 &&
                    ((!jsp_PWRITE && m_rx_sz[c] == 0) || (jsp_PWRITE && m_tx_sz[c] == DEPTH)))
                    m_err[c] = 1'b1;
                else if (here && jsp_PADDR[2:0] == 3'd2 && jsp_PWRITE && jsp_PWDATA[3])
                    m_err[c] = 1'b0;
            end
            m_int = m_nxt_int;
        end
    end

    // ---------------- scoreboard compare (every cycle, away from the edge) ----------------
    always @(negedge PCLK) begin
        logic [7:0] ed;
        logic       ee;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("rx_ready[%0d]", c), 32'(host_rx_ready_o[c]), 32'(exp_rx_q[c].size() < DEPTH));
            chk($sformatf("tx_valid[%0d]", c), 32'(host_tx_valid_o[c]), 32'(exp_tx_q[c].size() > 0));
            chk($sformatf("tx_data[%0d]", c), 32'(host_tx_data_o[8*c +: 8]),
                32'(exp_tx_q[c].size() > 0 ? exp_tx_q[c][0] : 8'h00));
        end
        chk("int_o", 32'(int_o), 32'(m_int));
        chk("pready", 32'(jsp_PREADY), 32'd1);
        exp_apb(ed, ee);
        chk("pslverr", 32'(jsp_PSLVERR), 32'(ee));
        if (!(jsp_PSEL && jsp_PENABLE && jsp_PWRITE)) chk("prdata", 32'(jsp_PRDATA), 32'(ed));
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rdata, output logic err);
        jsp_PSEL = 1'b1; jsp_PENABLE = 1'b0; jsp_PWRITE = wr; jsp_PADDR = addr; jsp_PWDATA = wdata;
        cyc();
        jsp_PENABLE = 1'b1;
        @(negedge PCLK);
        rdata = jsp_PRDATA;
        err   = jsp_PSLVERR;
        cyc();
        jsp_PSEL = 1'b0; jsp_PENABLE = 1'b0;
    endtask

    task automatic check_reset_counts(input string tag);
        logic [7:0] rd;
        logic       er;
        for (int c = 0; c < CH; c++) begin
            apb_xfer(1'b0, AW'(c * 8 + 3), 8'h00, rd, er);
            chk($sformatf("%s_rxcnt[%0d]", tag, c), 32'(rd), 32'd0);
            apb_xfer(1'b0, AW'(c * 8 + 4), 8'h00, rd, er);
            chk($sformatf("%s_txfree[%0d]", tag, c), 32'(rd), 32'd16);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 32'(host_rx_ready_o), 32'hF);
        chk({tag, "_tx_valid"}, 32'(host_tx_valid_o), 32'h0);
        chk({tag, "_tx_data"},  32'(host_tx_data_o), 32'h0);
        chk({tag, "_int"},      32'(int_o), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rd;
        logic       er;
        logic [7:0] base;

        // Power-on reset
        repeat (3) cyc();
        check_reset_outputs("t1_por");
        chk("t1_por_prdata", 32'(jsp_PRDATA), 32'h0);
        chk("t1_por_pslverr", 32'(jsp_PSLVERR), 32'h0);
        PRESETn = 1'b1;
        cyc();
        check_reset_counts("t1_por");

        // Fill ch2 RX from the host, then drain it over APB
        for (int i = 0; i < 16; i++) begin
            host_rx_valid_i[2] = 1'b1;
            host_rx_data_i[23:16] = 8'(8'h41 + i);
            cyc();
        end
        host_rx_valid_i[2] = 1'b0;
        chk("t2_rx_ready_full", 32'(host_rx_ready_o[2]), 32'd0);
        apb_xfer(1'b0, 6'h13, 8'h00, rd, er);
        chk("t2_rxcnt", 32'(rd), 32'd16);
        for (int i = 0; i < 17; i++) begin
            apb_xfer(1'b0, 6'h10, 8'h00, rd, er);
            chk($sformatf("t2_data%0d", i), 32'(rd), (i < 16) ? 32'(8'h41 + i) : 32'h0);
            chk($sformatf("t2_err%0d", i), 32'(er), (i < 16) ? 32'd0 : 32'd1);
        end
        apb_xfer(1'b0, 6'h12, 8'h00, rd, er);
        chk("t2_stat", 32'(rd), 32'h0E);
        apb_xfer(1'b1, 6'h12, 8'h08, rd, er);
        apb_xfer(1'b0, 6'h12, 8'h00, rd, er);
        chk("t2_stat_w1c", 32'(rd), 32'h06);

        // Overfill ch1 TX, then drain at full rate; three passes wrap the pointers
        for (int rep = 0; rep < 3; rep++) begin
            base = (rep == 0) ? 8'h10 : (rep == 1) ? 8'h60 : 8'hA0;
            host_tx_ready_i[1] = 1'b0;
            for (int i = 0; i < 17; i++) begin
                apb_xfer(1'b1, 6'h08, 8'(base + 8'(i)), rd, er);
                chk($sformatf("t3_wr_err%0d_%0d", rep, i), 32'(er), (i < 16) ? 32'd0 : 32'd1);
            end
            apb_xfer(1'b0, 6'h0C, 8'h00, rd, er);
            chk($sformatf("t3_txfree%0d", rep), 32'(rd), 32'd0);
            host_tx_ready_i[1] = 1'b1;
            for (int i = 0; i < 16; i++) begin
                @(negedge PCLK);
                chk($sformatf("t3_drain%0d_%0d", rep, i), 32'(host_tx_data_o[15:8]), 32'(base + 8'(i)));
                cyc();
            end
            host_tx_ready_i[1] = 1'b0;
            @(negedge PCLK);
            chk($sformatf("t3_empty%0d", rep), 32'(host_tx_valid_o[1]), 32'd0);
            cyc();
        end

        // ch0 RX at depth 8 with a push and a pop on every cycle
        for (int i = 0; i < 8; i++) begin
            host_rx_valid_i[0] = 1'b1;
            host_rx_data_i[7:0] = 8'(8'h80 + i);
            cyc();
        end
        host_rx_valid_i[0] = 1'b0;
        jsp_PSEL = 1'b1; jsp_PENABLE = 1'b0; jsp_PWRITE = 1'b0; jsp_PADDR = 6'h00;
        cyc();
        jsp_PENABLE = 1'b1;
        for (int k = 0; k < 20; k++) begin
            host_rx_valid_i[0] = 1'b1;
            host_rx_data_i[7:0] = 8'(8'h88 + k);
            @(negedge PCLK);
            chk($sformatf("t4_data%0d", k), 32'(jsp_PRDATA), 32'(8'h80 + k));
            cyc();
        end
        jsp_PSEL = 1'b0; jsp_PENABLE = 1'b0; host_rx_valid_i[0] = 1'b0;
        apb_xfer(1'b0, 6'h03, 8'h00, rd, er);
        chk("t4_rxcnt", 32'(rd), 32'd8);

        // ch3 interrupt sources and out-of-range channel
        apb_xfer(1'b1, 6'h19, 8'h01, rd, er);
        host_rx_valid_i[3] = 1'b1;
        host_rx_data_i[31:24] = 8'h5A;
        cyc();
        host_rx_valid_i[3] = 1'b0;
        chk("t5_int_latency", 32'(int_o), 32'd0);
        cyc();
        chk("t5_int_rx", 32'(int_o), 32'd1);
        apb_xfer(1'b0, 6'h18, 8'h00, rd, er);
        chk("t5_data", 32'(rd), 32'h5A);
        cyc();
        chk("t5_int_clear", 32'(int_o), 32'd0);
        apb_xfer(1'b1, 6'h19, 8'h02, rd, er);
        cyc();
        chk("t5_int_tx", 32'(int_o), 32'd1);
        apb_xfer(1'b0, 6'h28, 8'h00, rd, er);
        chk("t5_oor_err", 32'(er), 32'd1);
        chk("t5_oor_data", 32'(rd), 32'd0);
        apb_xfer(1'b1, 6'h2C, 8'h33, rd, er);
        chk("t5_oor_wr_err", 32'(er), 32'd1);
        apb_xfer(1'b1, 6'h19, 8'h00, rd, er);
        cyc();
        chk("t5_int_off", 32'(int_o), 32'd0);

        // Random traffic with a reset dropped in mid-stream
        for (int it = 0; it < 400; it++) begin
            host_rx_valid_i = CH'($urandom_range(0, 15));
            host_rx_data_i  = CH*8'($urandom);
            host_tx_ready_i = CH'($urandom_range(0, 15)) & CH'($urandom_range(0, 15));
            if (it == 200) begin
                PRESETn = 1'b0;
                #1;
                check_reset_outputs("t1_mid");
                cyc();
                cyc();
                host_rx_valid_i = '0;
                host_tx_ready_i = '0;
                PRESETn = 1'b1;
                cyc();
                check_reset_counts("t1_mid");
            end else if ($urandom_range(0, 1) == 1) begin
                apb_xfer(1'($urandom_range(0, 1)),
                         {3'($urandom_range(0, 7) < 6 ? $urandom_range(0, 3) : $urandom_range(4, 7)),
                          3'($urandom_range(0, 3) == 0 ? $urandom_range(1, 7) : 0)},
                         8'($urandom), rd, er);
            end else begin
                cyc();
            end
        end
        host_rx_valid_i = '0;
        host_tx_ready_i = '0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
